capp_array: RTL and testbench
=============================

Name: capp_array

Overview:
- Parametrised content-addressable parallel processor array: the successor to the single-op cam.
- Holds num_cells words of num_bits each, plus one tag bit per cell.
- Executes a command stream: set/clear tags, masked search (AND and OR accumulate), select-first, masked parallel write, first-responder read.
- Publishes match status (some/none/count) for the host-side controller sequencing CAPP algorithms.

Parameters:
- num_bits, 32, word width per cell
- num_cells, 100, number of cells (≥2)
- cnt_w, $clog2(num_cells+1), width of match_count

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  array can accept a command this cycle
- cmd_op  in  3  opcode, see Behaviour
- comparand  in  num_bits  search key, sampled on accept
- mask  in  num_bits  search bit-enable (1 = compare this bit), sampled on accept
- write_data  in  num_bits  data for WRITE, sampled on accept
- write_mask  in  num_bits  per-bit write enable for WRITE, sampled on accept
- tag_wires  out  num_cells  registered tag vector
- read_lines  out  num_bits  word of the first tagged cell, valid with read_valid
- read_valid  out  1  one-cycle pulse completing READ
- some_match  out  1  at least one tag set (registered status)
- none_match  out  1  no tag set; always equals ~some_match
- match_count  out  cnt_w  number of set tags

Behaviour:
- Opcodes: 0 NOP, 1 SET_ALL, 2 CLR_ALL, 3 SEARCH, 4 SEARCH_OR, 5 SELECT_FIRST, 6 WRITE, 7 READ.
- FSM states: IDLE, EXEC, STATUS.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch the op and all operands, then go to EXEC. NOP also traverses EXEC and STATUS.
  - EXEC: cmd_ready=0. Perform the op; registered effects become visible next cycle. Go to STATUS.
  - STATUS: cmd_ready=0. Recompute some_match, none_match and match_count from the new tags. Go to IDLE.
- Throughput: one command per 3 cycles. Status outputs are valid from the cycle cmd_ready returns high.
- Cell i matches when ((word[i] ^ comparand) & mask) == 0. mask=0 matches every cell.
- SET_ALL: tags ← all 1.
- CLR_ALL: tags ← all 0.
- SEARCH: tags ← tags & match.
- SEARCH_OR: tags ← tags | match.
- SELECT_FIRST: tags ← one-hot of the lowest-index set tag. No tags set → tags stay 0.
- WRITE: for every tagged cell, word ← (word & ~write_mask) | (write_data & write_mask).
  - Tags unchanged.
  - No tags set → memory unchanged.
- READ:
  - read_lines ← word of the lowest-index tagged cell, or 0 if none tagged.
  - read_valid=1 for exactly the cycle after EXEC; read_lines holds its value until the next READ.
  - Tags unchanged.
- All-ones tag vector: match_count = num_cells with no overflow (cnt_w sized accordingly).
- Operands are used only from the latched copies; input changes after accept have no effect.
- RST, at any cycle including mid-command:
  - FSM ← IDLE; the in-flight command is dropped with no partial write.
  - All words ← 0, tags ← 0, read_lines ← 0, read_valid ← 0.
  - some_match ← 0, none_match ← 1, match_count ← 0.
  - cmd_ready = 1 in the first cycle after RST deasserts.

Decomposition:
- Package capp_pkg:
  - opcode localparams OP_NOP..OP_READ
  - FSM state encoding (2-bit)
  - function popcount(num_cells) returning cnt_w
- One sub-module: capp_first_responder, parameter num_cells.
  - Input tags.
  - Outputs: onehot (lowest set bit), index ($clog2(num_cells)), any.
  - Used by both SELECT_FIRST and READ.
- Match vector generation and the write loop stay inline as generate loops.

Test Plan:
- Reset: hold RST 2 cycles, release → tag_wires=0, none_match=1, match_count=0, cmd_ready=1; READ then returns read_lines=0 with read_valid pulse.
- Fill cells: SET_ALL; WRITE data=0, mask=all 1; then per cell i=1..num_cells run SEARCH(comp=0, mask=all 1), SELECT_FIRST, WRITE(data=i, mask=all 1). Then SEARCH(comp=35, mask=all 1) → only tag[34]=1, match_count=1; READ → read_lines=35.
- Masked search/OR: after fill, SET_ALL, SEARCH(comp=0, mask=0x1) → 50 even-valued tags, match_count=50. Then SEARCH_OR(comp=1, mask=0xFFFFFFFF) → match_count=51, includes cell 0.
- Masked write: tag cells holding 4..7 via SET_ALL + SEARCH(comp=4, mask=0xFFFFFFFC); WRITE(data=0x100, write_mask=0x100) → those cells read 0x104..0x107, others unchanged.
- Empty cases: CLR_ALL then SELECT_FIRST → tags stay 0; WRITE → no cell changes (verify with SEARCH); READ → read_lines=0, none_match=1.
- Mid-op reset: accept WRITE, assert RST during EXEC → no word modified (all 0), FSM IDLE, cmd_ready=1 after release. Also hold cmd_valid during EXEC/STATUS → not accepted until IDLE.

Source files
------------

// File: rtl/capp_pkg.sv
// Shared definitions for the content-addressable parallel processor array:
// opcodes, controller state encoding and a tag population counter.
package capp_pkg;

    localparam logic [2:0] OP_NOP          = 3'd0;
    localparam logic [2:0] OP_SET_ALL      = 3'd1;
    localparam logic [2:0] OP_CLR_ALL      = 3'd2;
    localparam logic [2:0] OP_SEARCH       = 3'd3;
    localparam logic [2:0] OP_SEARCH_OR    = 3'd4;
    localparam logic [2:0] OP_SELECT_FIRST = 3'd5;
    localparam logic [2:0] OP_WRITE        = 3'd6;
    localparam logic [2:0] OP_READ         = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_STATUS = 2'd2
    } capp_state_t;

    // Largest array the population counter handles; callers zero-extend.
    localparam int MAX_CELLS = 1024;

    function automatic logic [15:0] popcount(input logic [MAX_CELLS-1:0] v);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < MAX_CELLS; i++) begin
            acc = acc + 16'(v[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/capp_first_responder.sv
// Lowest-index set tag resolver: one-hot mask, binary index and any-set flag.
module capp_first_responder
    import capp_pkg::*;
#(
    parameter int num_cells = 100,
    parameter int idx_w     = $clog2(num_cells)
) (
    input  logic [num_cells-1:0] tags,
    output logic [num_cells-1:0] onehot,
    output logic [idx_w-1:0]     index,
    output logic                 any
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = tags & (~tags + num_cells'(1));
    assign any    = |tags;

    always_comb begin
        index = '0;
        for (int i = num_cells - 1; i >= 0; i--) begin
            if (tags[i]) begin
                index = idx_w'(i);
            end
        end
    end

endmodule

// File: rtl/capp_array.sv
// Content-addressable parallel processor: word store plus tag bit per cell,
// driven by a three-cycle accept/execute/status command sequence.
module capp_array
    import capp_pkg::*;
#(
    parameter int num_bits  = 32,
    parameter int num_cells = 100,
    parameter int cnt_w     = $clog2(num_cells + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [num_bits-1:0]  comparand,
    input  logic [num_bits-1:0]  mask,
    input  logic [num_bits-1:0]  write_data,
    input  logic [num_bits-1:0]  write_mask,
    output logic [num_cells-1:0] tag_wires,
    output logic [num_bits-1:0]  read_lines,
    output logic                 read_valid,
    output logic                 some_match,
    output logic                 none_match,
    output logic [cnt_w-1:0]     match_count
);

    localparam int idx_w = $clog2(num_cells);

    capp_state_t          state_reg, state_next;
    logic [2:0]           op_reg;
    logic [num_bits-1:0]  comparand_reg, mask_reg, write_data_reg, write_mask_reg;
    logic [num_cells-1:0] tags_reg;
    logic [num_bits-1:0]  words_reg  [num_cells];
    logic [num_bits-1:0]  words_next [num_cells];
    logic [num_cells-1:0] match_vec;
    logic [num_bits-1:0]  read_lines_reg;
    logic                 read_valid_reg;
    logic                 some_match_reg;
    logic [cnt_w-1:0]     match_count_reg;

    logic [num_cells-1:0] first_onehot;
    logic [idx_w-1:0]     first_index;
    logic                 first_any;

    capp_first_responder #(
        .num_cells (num_cells),
        .idx_w     (idx_w)
    ) u_first (
        .tags   (tags_reg),
        .onehot (first_onehot),
        .index  (first_index),
        .any    (first_any)
    );

    // Per-cell comparator and masked write merge, all cells in parallel.
    for (genvar gi = 0; gi < num_cells; gi++) begin : g_cell
        assign match_vec[gi]  = ~|((words_reg[gi] ^ comparand_reg) & mask_reg);
        assign words_next[gi] = tags_reg[gi]
            ? ((words_reg[gi] & ~write_mask_reg) | (write_data_reg & write_mask_reg))
            : words_reg[gi];
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = ST_EXEC;
            end
            ST_EXEC:   state_next = ST_STATUS;
            ST_STATUS: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= ST_IDLE;
            op_reg          <= OP_NOP;
            comparand_reg   <= '0;
            mask_reg        <= '0;
            write_data_reg  <= '0;
            write_mask_reg  <= '0;
            tags_reg        <= '0;
            read_lines_reg  <= '0;
            read_valid_reg  <= 1'b0;
            some_match_reg  <= 1'b0;
            match_count_reg <= '0;
            for (int i = 0; i < num_cells; i++) begin
                words_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            read_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_reg         <= cmd_op;
                        comparand_reg  <= comparand;
                        mask_reg       <= mask;
                        write_data_reg <= write_data;
                        write_mask_reg <= write_mask;
                    end
                end
                ST_EXEC: begin
                    case (op_reg)
                        OP_SET_ALL:      tags_reg <= '1;
                        OP_CLR_ALL:      tags_reg <= '0;
                        OP_SEARCH:       tags_reg <= tags_reg & match_vec;
                        OP_SEARCH_OR:    tags_reg <= tags_reg | match_vec;
                        OP_SELECT_FIRST: tags_reg <= first_onehot;
                        OP_WRITE: begin
                            for (int i = 0; i < num_cells; i++) begin
                                words_reg[i] <= words_next[i];
                            end
                        end
                        OP_READ: begin
                            read_valid_reg <= 1'b1;
                            read_lines_reg <= first_any ? words_reg[first_index] : '0;
                        end
                        default: ;
                    endcase
                end
                ST_STATUS: begin
                    some_match_reg  <= |tags_reg;
                    match_count_reg <= cnt_w'(popcount(MAX_CELLS'(tags_reg)));
                end
                default: ;
            endcase
        end
    end

    assign tag_wires   = tags_reg;
    assign read_lines  = read_lines_reg;
    assign read_valid  = read_valid_reg;
    assign some_match  = some_match_reg;
    assign none_match  = ~some_match_reg;
    assign match_count = match_count_reg;

endmodule

// File: tb/tb_capp_array.sv
// Directed bench for capp_array: builds a 1..100 word image, then exercises
// masked search/OR, masked write, empty-tag cases and reset mid-command.
module tb_capp_array;

    localparam int NB = 32;
    localparam int NC = 100;
    localparam int CW = $clog2(NC + 1);

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [NB-1:0] comparand = '0, mask = '0, write_data = '0, write_mask = '0;
    logic [NC-1:0] tag_wires;
    logic [NB-1:0] read_lines;
    logic          read_valid, some_match, none_match;
    logic [CW-1:0] match_count;

    int checks = 0;
    int failures = 0;
    logic          last_rv;
    logic [NB-1:0] last_rl;
    logic [NC-1:0] exp_tags;

    capp_array #(.num_bits(NB), .num_cells(NC)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .comparand(comparand), .mask(mask),
        .write_data(write_data), .write_mask(write_mask), .tag_wires(tag_wires),
        .read_lines(read_lines), .read_valid(read_valid), .some_match(some_match),
        .none_match(none_match), .match_count(match_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // Issue one command and step through EXEC and STATUS; read outputs are
    // captured in the cycle after EXEC.
    task automatic do_cmd(input logic [2:0] op, input logic [NB-1:0] comp,
                          input logic [NB-1:0] msk, input logic [NB-1:0] wd,
                          input logic [NB-1:0] wm);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!cmd_ready) check("ready_wait", 128'(cmd_ready), 128'd1);
        cmd_op = op; comparand = comp; mask = msk; write_data = wd; write_mask = wm;
        cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        comparand = ~comp;
        @(posedge CLK); #1;
        last_rv = read_valid;
        last_rl = read_lines;
        @(posedge CLK); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_tags", 128'(tag_wires), 128'd0);
        check("rst_none", 128'(none_match), 128'd1);
        check("rst_some", 128'(some_match), 128'd0);
        check("rst_count", 128'(match_count), 128'd0);
        check("rst_ready", 128'(cmd_ready), 128'd1);
        do_cmd(3'd7, '0, '0, '0, '0);
        check("rst_read_valid", 128'(last_rv), 128'd1);
        check("rst_read_lines", 128'(last_rl), 128'd0);
        check("read_valid_pulse", 128'(read_valid), 128'd0);

        // Fill: cell k holds k+1
        do_cmd(3'd1, '0, '0, '0, '0);
        check("setall_count", 128'(match_count), 128'd100);
        check("setall_some", 128'(some_match), 128'd1);
        check("setall_none", 128'(none_match), 128'd0);
        do_cmd(3'd6, '0, '0, '0, '1);
        for (int i = 1; i <= NC; i++) begin
            do_cmd(3'd1, '0, '0, '0, '0);
            do_cmd(3'd3, '0, '1, '0, '0);
            do_cmd(3'd5, '0, '0, '0, '0);
            do_cmd(3'd6, '0, '0, NB'(i), '1);
        end
        do_cmd(3'd1, '0, '0, '0, '0);
        do_cmd(3'd3, 32'd35, '1, '0, '0);
        exp_tags = '0; exp_tags[34] = 1'b1;
        check("search35_tags", 128'(tag_wires), 128'(exp_tags));
        check("search35_count", 128'(match_count), 128'd1);
        do_cmd(3'd7, '0, '0, '0, '0);
        check("read35", 128'(last_rl), 128'd35);

        // Masked search and OR accumulate
        do_cmd(3'd1, '0, '0, '0, '0);
        do_cmd(3'd3, '0, 32'h1, '0, '0);
        check("even_count", 128'(match_count), 128'd50);
        check("even_cell0", 128'(tag_wires[0]), 128'd0);
        do_cmd(3'd4, 32'd1, 32'hFFFF_FFFF, '0, '0);
        check("or_count", 128'(match_count), 128'd51);
        check("or_cell0", 128'(tag_wires[0]), 128'd1);
        do_cmd(3'd5, '0, '0, '0, '0);
        exp_tags = '0; exp_tags[0] = 1'b1;
        check("selfirst_tags", 128'(tag_wires), 128'(exp_tags));
        do_cmd(3'd7, '0, '0, '0, '0);
        check("read_cell0", 128'(last_rl), 128'd1);

        // Masked write on cells holding 4..7
        do_cmd(3'd1, '0, '0, '0, '0);
        do_cmd(3'd3, 32'd4, 32'hFFFF_FFFC, '0, '0);
        check("mw_tags", 128'(tag_wires), 128'h78);
        do_cmd(3'd6, '0, '0, 32'h100, 32'h100);
        check("mw_tags_kept", 128'(tag_wires), 128'h78);
        do_cmd(3'd1, '0, '0, '0, '0);
        do_cmd(3'd3, 32'h105, '1, '0, '0);
        exp_tags = '0; exp_tags[4] = 1'b1;
        check("mw_105_tags", 128'(tag_wires), 128'(exp_tags));
        do_cmd(3'd7, '0, '0, '0, '0);
        check("mw_read_105", 128'(last_rl), 128'h105);
        do_cmd(3'd1, '0, '0, '0, '0);
        do_cmd(3'd3, 32'h100, 32'h100, '0, '0);
        check("mw_bit8_count", 128'(match_count), 128'd4);
        do_cmd(3'd1, '0, '0, '0, '0);
        do_cmd(3'd3, 32'd8, '1, '0, '0);
        exp_tags = '0; exp_tags[7] = 1'b1;
        check("mw_untouched8", 128'(tag_wires), 128'(exp_tags));

        // Empty tag set
        do_cmd(3'd2, '0, '0, '0, '0);
        do_cmd(3'd5, '0, '0, '0, '0);
        check("empty_sel_tags", 128'(tag_wires), 128'd0);
        check("empty_none", 128'(none_match), 128'd1);
        do_cmd(3'd6, '0, '0, 32'hDEAD, '1);
        do_cmd(3'd7, '0, '0, '0, '0);
        check("empty_read_valid", 128'(last_rv), 128'd1);
        check("empty_read_lines", 128'(last_rl), 128'd0);
        do_cmd(3'd1, '0, '0, '0, '0);
        do_cmd(3'd3, 32'hDEAD, '1, '0, '0);
        check("empty_write_none", 128'(match_count), 128'd0);

        // cmd_valid held: only accepted from IDLE
        cmd_op = 3'd0; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        check("hold_exec_ready", 128'(cmd_ready), 128'd0);
        @(posedge CLK); #1;
        check("hold_status_ready", 128'(cmd_ready), 128'd0);
        @(posedge CLK); #1;
        check("hold_idle_ready", 128'(cmd_ready), 128'd1);
        @(posedge CLK); #1;
        check("hold_reaccept", 128'(cmd_ready), 128'd0);
        cmd_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset during EXEC of a WRITE
        do_cmd(3'd1, '0, '0, '0, '0);
        cmd_op = 3'd6; write_data = '1; write_mask = '1; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0; RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("midrst_ready", 128'(cmd_ready), 128'd1);
        check("midrst_tags", 128'(tag_wires), 128'd0);
        check("midrst_count", 128'(match_count), 128'd0);
        check("midrst_none", 128'(none_match), 128'd1);
        do_cmd(3'd1, '0, '0, '0, '0);
        do_cmd(3'd3, '0, '1, '0, '0);
        check("midrst_all_zero", 128'(match_count), 128'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
